regfile_dump_reader: RTL and testbench

Debug read-out engine for the single-cycle CPU register file. On a start request it stalls the CPU and walks the register file's read port from FIRST_REG to LAST_REG. Each word is streamed out on a valid/ready interface, with its index, a last flag and a running checksum. It is intended to feed a UART/LED debug path.

---
 rtl/regfile_dump_reader.sv | 157 +++++++++++++++
 tb/tb_regfile_dump_reader.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_reader.sv
// Register-file dump engine: stalls the CPU, walks the register file read port
// from FIRST_REG to LAST_REG and streams each word out on a valid/ready
// interface with its index, a last flag and a running checksum.

// Elaboration-time guard on the register range; the design itself never
// depends on this module, it only stops a bad parameter set from building.
module regfile_dump_reader_param_chk #(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) ();
  if ((FIRST_REG < 0) || (FIRST_REG > LAST_REG) || (LAST_REG > 31)) begin : g_bad_range
    $error("regfile_dump_reader: need 0 <= FIRST_REG <= LAST_REG <= 31");
  end
endmodule

module regfile_dump_reader #(
  parameter int DATA_W    = 32,
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [4:0]        reg_raddr,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              cpu_stall,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  output logic [4:0]        dump_index,
  output logic              dump_last,
  output logic [DATA_W-1:0] checksum,
  output logic              done,
  output logic              busy
);

  localparam logic [4:0] FIRST_ADDR = 5'(FIRST_REG);
  localparam logic [4:0] LAST_ADDR  = 5'(LAST_REG);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [4:0]        raddr_q, raddr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [4:0]        index_q, index_d;
  logic              last_q, last_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] csum_q, csum_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  regfile_dump_reader_param_chk #(
    .FIRST_REG (FIRST_REG),
    .LAST_REG  (LAST_REG)
  ) u_param_chk ();

  // Next-state and registered-output logic of the dump sequencer.
  always_comb begin
    state_d = state_q;
    raddr_d = raddr_q;
    data_d  = data_q;
    index_d = index_q;
    last_d  = last_q;
    valid_d = valid_q;
    csum_d  = csum_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_READ;
          raddr_d = FIRST_ADDR;
          csum_d  = {DATA_W{1'b0}};
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        // Read port is combinational, so the word is captured on this edge.
        data_d  = reg_rdata;
        index_d = raddr_q;
        last_d  = (raddr_q == LAST_ADDR);
        valid_d = 1'b1;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (dump_ready) begin
          csum_d  = csum_q + data_q;
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (last_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            // last_q guards the increment, so the address never passes LAST_REG.
            raddr_d = raddr_q + 5'd1;
            state_d = ST_READ;
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any dump at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      raddr_q <= 5'd0;
      data_q  <= {DATA_W{1'b0}};
      index_q <= 5'd0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      csum_q  <= {DATA_W{1'b0}};
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      raddr_q <= raddr_d;
      data_q  <= data_d;
      index_q <= index_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      csum_q  <= csum_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign reg_raddr  = raddr_q;
  assign cpu_stall  = busy_q;
  assign busy       = busy_q;
  assign dump_valid = valid_q;
  assign dump_data  = data_q;
  assign dump_index = index_q;
  assign dump_last  = last_q;
  assign checksum   = csum_q;
  assign done       = done_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: full dumps, backpressure, start
// handling, mid-dump reset and a single-register configuration.
module tb_regfile_dump_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start1, ready1, start2, ready2;
  logic [4:0]  raddr1, raddr2, index1, index2;
  logic [31:0] rdata1, rdata2, data1, data2, csum1, csum2;
  logic        stall1, stall2, valid1, valid2, last1, last2;
  logic        done1, done2, busy1, busy2;

  int total = 0;
  int bad   = 0;
  logic [31:0] sum;

  // Register file model: reg i = 0x10000000+i, reg0 = 0.
  function automatic logic [31:0] exp_data(input int i);
    if (i == 0) return 32'h0000_0000;
    else        return 32'h1000_0000 + 32'(i);
  endfunction

  assign rdata1 = exp_data(int'(raddr1));
  assign rdata2 = (raddr2 == 5'd8) ? 32'hDEAD_BEEF : exp_data(int'(raddr2));

  regfile_dump_reader #(.DATA_W(32), .FIRST_REG(0), .LAST_REG(31)) dut (
    .clk(clk), .reset(rst_n), .start(start1), .reg_raddr(raddr1), .reg_rdata(rdata1),
    .cpu_stall(stall1), .dump_valid(valid1), .dump_ready(ready1), .dump_data(data1),
    .dump_index(index1), .dump_last(last1), .checksum(csum1), .done(done1), .busy(busy1)
  );

  regfile_dump_reader #(.DATA_W(32), .FIRST_REG(8), .LAST_REG(8)) dut8 (
    .clk(clk), .reset(rst_n), .start(start2), .reg_raddr(raddr2), .reg_rdata(rdata2),
    .cpu_stall(stall2), .dump_valid(valid2), .dump_ready(ready2), .dump_data(data2),
    .dump_index(index2), .dump_last(last2), .checksum(csum2), .done(done2), .busy(busy2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Enters in READ for index i; leaves after the handshake edge.
  task automatic beat(input int i, input int hold, input bit pulse);
    chk("read_raddr", 32'(raddr1), 32'(i));
    chk("read_valid", 32'(valid1), 32'd0);
    chk("read_stall", 32'(stall1), 32'd1);
    tick();
    chk("send_valid", 32'(valid1), 32'd1);
    chk("send_data",  data1, exp_data(i));
    chk("send_index", 32'(index1), 32'(i));
    chk("send_last",  32'(last1), (i == 31) ? 32'd1 : 32'd0);
    if (pulse) start1 = 1'b1;
    if (hold > 0) begin
      ready1 = 1'b0;
      for (int k = 0; k < hold; k++) begin
        tick();
        chk("bp_valid", 32'(valid1), 32'd1);
        chk("bp_data",  data1, exp_data(i));
        chk("bp_index", 32'(index1), 32'(i));
        chk("bp_raddr", 32'(raddr1), 32'(i));
        chk("bp_stall", 32'(stall1), 32'd1);
      end
      ready1 = 1'b1;
    end
    tick();
    if (pulse) start1 = 1'b0;
    sum = sum + exp_data(i);
    chk("hs_valid", 32'(valid1), 32'd0);
    chk("hs_csum",  csum1, sum);
  endtask

  // Enters in DONE; leaves in IDLE.
  task automatic finish_dump();
    chk("done_pulse", 32'(done1), 32'd1);
    chk("done_last",  32'(last1), 32'd0);
    chk("done_busy",  32'(busy1), 32'd1);
    chk("done_csum",  csum1, 32'hF000_01F0);
    tick();
    chk("idle_done",  32'(done1), 32'd0);
    chk("idle_busy",  32'(busy1), 32'd0);
    chk("idle_stall", 32'(stall1), 32'd0);
    chk("idle_csum",  csum1, 32'hF000_01F0);
  endtask

  initial begin
    rst_n = 1'b0; start1 = 1'b1; ready1 = 1'b1; start2 = 1'b0; ready2 = 1'b1;
    sum = 32'h0;
    // Reset with start and ready asserted
    repeat (3) tick();
    chk("rst_raddr", 32'(raddr1), 32'd0);
    chk("rst_valid", 32'(valid1), 32'd0);
    chk("rst_data",  data1, 32'd0);
    chk("rst_index", 32'(index1), 32'd0);
    chk("rst_last",  32'(last1), 32'd0);
    chk("rst_csum",  csum1, 32'd0);
    chk("rst_done",  32'(done1), 32'd0);
    chk("rst_busy",  32'(busy1), 32'd0);
    chk("rst_stall", 32'(stall1), 32'd0);
    chk("rst_busy8", 32'(busy2), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("start_busy",  32'(busy1), 32'd1);
    chk("start_stall", 32'(stall1), 32'd1);
    chk("start_csum",  csum1, 32'd0);
    start1 = 1'b0;

    // Full dump; start pulse during beat 5 must be ignored
    sum = 32'h0;
    for (int i = 0; i < 32; i++) beat(i, 0, (i == 5));
    finish_dump();

    // Backpressure on index 3, start held high through done
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    sum = 32'h0;
    for (int i = 0; i < 32; i++) begin
      if (i == 31) start1 = 1'b1;
      beat(i, (i == 3) ? 5 : 0, 1'b0);
    end
    finish_dump();
    tick();
    chk("restart_busy",  32'(busy1), 32'd1);
    chk("restart_raddr", 32'(raddr1), 32'd0);
    chk("restart_csum",  csum1, 32'd0);
    start1 = 1'b0;
    sum = 32'h0;
    for (int i = 0; i < 32; i++) beat(i, 0, 1'b0);
    finish_dump();

    // Reset mid-dump while index 10 is waiting in SEND
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    sum = 32'h0;
    for (int i = 0; i < 10; i++) beat(i, 0, 1'b0);
    ready1 = 1'b0;
    tick();
    chk("pre_rst_valid", 32'(valid1), 32'd1);
    chk("pre_rst_index", 32'(index1), 32'd10);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(valid1), 32'd0);
    chk("arst_busy",  32'(busy1), 32'd0);
    chk("arst_stall", 32'(stall1), 32'd0);
    chk("arst_csum",  csum1, 32'd0);
    tick();
    chk("arst_nodone", 32'(done1), 32'd0);
    #2 rst_n = 1'b1;
    ready1 = 1'b1;
    tick();
    chk("post_rst_idle", 32'(busy1), 32'd0);
    chk("post_rst_done", 32'(done1), 32'd0);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("rerun_raddr", 32'(raddr1), 32'd0);
    chk("rerun_csum",  csum1, 32'd0);
    sum = 32'h0;
    for (int i = 0; i < 32; i++) beat(i, 0, 1'b0);
    finish_dump();

    // Single-register configuration FIRST_REG=LAST_REG=8
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    chk("r8_busy",  32'(busy2), 32'd1);
    chk("r8_raddr", 32'(raddr2), 32'd8);
    chk("r8_csum0", csum2, 32'd0);
    tick();
    chk("r8_valid", 32'(valid2), 32'd1);
    chk("r8_index", 32'(index2), 32'd8);
    chk("r8_data",  data2, 32'hDEAD_BEEF);
    chk("r8_last",  32'(last2), 32'd1);
    tick();
    chk("r8_done",  32'(done2), 32'd1);
    chk("r8_csum",  csum2, 32'hDEAD_BEEF);
    chk("r8_vdrop", 32'(valid2), 32'd0);
    chk("r8_ldrop", 32'(last2), 32'd0);
    tick();
    chk("r8_idle_done", 32'(done2), 32'd0);
    chk("r8_idle_busy", 32'(busy2), 32'd0);
    chk("r8_idle_csum", csum2, 32'hDEAD_BEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
